// File: rtl/ex_mem_if.sv
// EX->MEM pipeline bus: EX-stage payload in, registered MEM-stage payload out,
// plus the multi-cycle multiply-accumulate feedback path back to EX.
interface ex_mem_if;
  logic [4:0]  ex_waddr_i;
  logic        ex_reg_we_i;
  logic [31:0] ex_alu_res_i;
  logic        ex_hi_we_i;
  logic        ex_lo_we_i;
  logic [31:0] ex_hi_i;
  logic [31:0] ex_lo_i;
  logic [63:0] hilo_temp_i;
  logic [1:0]  cnt_i;

  logic [4:0]  mem_waddr_o;
  logic        mem_reg_we_o;
  logic [31:0] mem_alu_res_o;
  logic        mem_hi_we_o;
  logic        mem_lo_we_o;
  logic [31:0] mem_hi_o;
  logic [31:0] mem_lo_o;
  logic [63:0] hilo_temp_o;
  logic [1:0]  cnt_o;

  // EX side drives the payload and consumes the feedback
  modport master (
    output ex_waddr_i, ex_reg_we_i, ex_alu_res_i, ex_hi_we_i, ex_lo_we_i,
           ex_hi_i, ex_lo_i, hilo_temp_i, cnt_i,
    input  mem_waddr_o, mem_reg_we_o, mem_alu_res_o, mem_hi_we_o, mem_lo_we_o,
           mem_hi_o, mem_lo_o, hilo_temp_o, cnt_o
  );

  // the pipeline register itself
  modport slave (
    input  ex_waddr_i, ex_reg_we_i, ex_alu_res_i, ex_hi_we_i, ex_lo_we_i,
           ex_hi_i, ex_lo_i, hilo_temp_i, cnt_i,
    output mem_waddr_o, mem_reg_we_o, mem_alu_res_o, mem_hi_we_o, mem_lo_we_o,
           mem_hi_o, mem_lo_o, hilo_temp_o, cnt_o
  );
endinterface

// File: rtl/ex_mem.sv
// EX/MEM pipeline register.
// stall_i[3]/[4] select Pass (EX running), Bubble (EX stalled, MEM running:
// insert a NOP and park the multi-cycle MAC state) or Hold (both stalled).
// Optional flush port, compiled in with macro EX_MEM_FLUSH_EN.
module ex_mem (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] stall_i,
`ifdef EX_MEM_FLUSH_EN
  input  logic       flush_i,
`endif
  ex_mem_if.slave    bus
);

  typedef struct packed {
    logic [4:0]  waddr;
    logic        reg_we;
    logic [31:0] alu_res;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi;
    logic [31:0] lo;
  } mem_t;

  mem_t        mem_q, mem_d;
  logic [63:0] hilo_q, hilo_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        clr;

  // flush acts exactly like reset, so it is folded into one clear term
`ifdef EX_MEM_FLUSH_EN
  assign clr = rst | flush_i;
`else
  assign clr = rst;
`endif

  // stall decode; only bits 3 and 4 matter, EX-run/MEM-stall is held
  always_comb begin
    mem_d  = mem_q;
    hilo_d = hilo_q;
    cnt_d  = cnt_q;
    if (!stall_i[3] && !stall_i[4]) begin
      // pass: latch EX payload, MAC state no longer needed
      mem_d.waddr   = bus.ex_waddr_i;
      mem_d.reg_we  = bus.ex_reg_we_i;
      mem_d.alu_res = bus.ex_alu_res_i;
      mem_d.hi_we   = bus.ex_hi_we_i;
      mem_d.lo_we   = bus.ex_lo_we_i;
      mem_d.hi      = bus.ex_hi_i;
      mem_d.lo      = bus.ex_lo_i;
      hilo_d        = '0;
      cnt_d         = '0;
    end else if (stall_i[3] && !stall_i[4]) begin
      // bubble: NOP to MEM so the stalled instruction is not written twice
      mem_d  = '0;
      hilo_d = bus.hilo_temp_i;
      cnt_d  = bus.cnt_i;
    end
  end

  // state update, clear has priority over the stall decode
  always_ff @(posedge clk) begin
    if (clr) begin
      mem_q  <= '0;
      hilo_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      hilo_q <= hilo_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.mem_waddr_o   = mem_q.waddr;
  assign bus.mem_reg_we_o  = mem_q.reg_we;
  assign bus.mem_alu_res_o = mem_q.alu_res;
  assign bus.mem_hi_we_o   = mem_q.hi_we;
  assign bus.mem_lo_we_o   = mem_q.lo_we;
  assign bus.mem_hi_o      = mem_q.hi;
  assign bus.mem_lo_o      = mem_q.lo;
  assign bus.hilo_temp_o   = hilo_q;
  assign bus.cnt_o         = cnt_q;

endmodule

// File: tb/tb_ex_mem.sv
// Directed bench for ex_mem: reset, pass, bubble, hold, stall decode corners,
// cnt pass-through, reset during stall and (with EX_MEM_FLUSH_EN) flush.
module tb_ex_mem;
  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] stall;
  logic       flush;
  int         checks = 0;
  int         errors = 0;

  ex_mem_if bus ();

  ex_mem dut (
    .clk     (clk),
    .rst     (rst),
    .stall_i (stall),
`ifdef EX_MEM_FLUSH_EN
    .flush_i (flush),
`endif
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // observed outputs in one vector: waddr,we,alu,hwe,lwe,hi,lo,hilo,cnt
  logic [169:0] obs;
  assign obs = {bus.mem_waddr_o, bus.mem_reg_we_o, bus.mem_alu_res_o,
                bus.mem_hi_we_o, bus.mem_lo_we_o, bus.mem_hi_o, bus.mem_lo_o,
                bus.hilo_temp_o, bus.cnt_o};

  function automatic logic [169:0] mk(logic [4:0] wa, logic we, logic [31:0] alu,
                                      logic hwe, logic lwe, logic [31:0] hi,
                                      logic [31:0] lo, logic [63:0] hl, logic [1:0] c);
    return {wa, we, alu, hwe, lwe, hi, lo, hl, c};
  endfunction

  task automatic set_ex(logic [4:0] wa, logic we, logic [31:0] alu, logic hwe,
                        logic lwe, logic [31:0] hi, logic [31:0] lo,
                        logic [63:0] hl, logic [1:0] c);
    bus.ex_waddr_i   = wa;
    bus.ex_reg_we_i  = we;
    bus.ex_alu_res_i = alu;
    bus.ex_hi_we_i   = hwe;
    bus.ex_lo_we_i   = lwe;
    bus.ex_hi_i      = hi;
    bus.ex_lo_i      = lo;
    bus.hilo_temp_i  = hl;
    bus.cnt_i        = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [169:0] exp;
    rst = 1'b1; stall = 6'b0; flush = 1'b0;
    set_ex(5'd31, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFF, 2'd3);
    tick();
    exp = '0;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset got %h exp %h", obs, exp); end
  endtask

  task automatic test_pass();
    logic [169:0] exp;
    rst = 1'b0; stall = 6'b0;
    set_ex(5'd7, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 32'h0, 64'hFF, 2'd2);
    tick();
    exp = mk(5'd7, 1'b1, 32'h12345678, 1'b0, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL pass got %h exp %h", obs, exp); end
  endtask

  task automatic test_hilo();
    logic [169:0] exp;
    stall = 6'b0;
    set_ex(5'd0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A, 64'h0, 2'd0);
    tick();
    exp = mk(5'd0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A, 64'h0, 2'd0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL hi_write got %h exp %h", obs, exp); end
  endtask

  task automatic test_bubble();
    logic [169:0] exp;
    stall = 6'b001000;
    set_ex(5'd9, 1'b1, 32'h0000_0011, 1'b0, 1'b1, 32'h0, 32'h22, 64'h0000_0001_FFFF_FFFF, 2'd1);
    tick();
    exp = mk(5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 64'h0000_0001_FFFF_FFFF, 2'd1);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL bubble got %h exp %h", obs, exp); end
    // released: instruction delivered once, MAC state cleared
    stall = 6'b0;
    bus.hilo_temp_i = 64'h55; bus.cnt_i = 2'd3;
    tick();
    exp = mk(5'd9, 1'b1, 32'h11, 1'b0, 1'b1, 32'h0, 32'h22, 64'h0, 2'd0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL bubble_release got %h exp %h", obs, exp); end
    // next instruction has no writes: no duplicate write enable
    set_ex(5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0);
    tick();
    exp = '0;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL no_dup_we got %h exp %h", obs, exp); end
  endtask

  task automatic test_hold();
    logic [169:0] exp;
    stall = 6'b0;
    set_ex(5'd3, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h0, 32'h1111, 64'h0, 2'd0);
    tick();
    exp = mk(5'd3, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1, 32'h0, 32'h1111, 64'h0, 2'd0);
    stall = 6'b011000;
    for (int i = 0; i < 3; i++) begin
      set_ex(5'(i + 20), 1'b0, 32'h9000 + i, 1'b1, 1'b0, 32'h77, 32'h88, 64'h1234 + i, 2'(i));
      tick();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL hold_%0d got %h exp %h", i, obs, exp); end
    end
    // hold also preserves parked MAC state
    stall = 6'b001000;
    set_ex(5'd1, 1'b1, 32'h1, 1'b0, 1'b0, 32'h0, 32'h0, 64'hABCD_0000_0000_1234, 2'd2);
    tick();
    stall = 6'b011000;
    bus.hilo_temp_i = 64'h1; bus.cnt_i = 2'd0;
    tick();
    exp = mk(5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 64'hABCD_0000_0000_1234, 2'd2);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL hold_hilo got %h exp %h", obs, exp); end
  endtask

  task automatic test_stall_decode();
    logic [169:0] exp;
    // load a known state
    stall = 6'b0;
    set_ex(5'd12, 1'b1, 32'h0BAD_CAFE, 1'b1, 1'b1, 32'h3, 32'h4, 64'h0, 2'd0);
    tick();
    exp = mk(5'd12, 1'b1, 32'h0BADCAFE, 1'b1, 1'b1, 32'h3, 32'h4, 64'h0, 2'd0);
    // bit3=0, bit4=1: treated as hold
    stall = 6'b010000;
    set_ex(5'd13, 1'b0, 32'h5, 1'b0, 1'b0, 32'h6, 32'h7, 64'h8, 2'd1);
    tick();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL illegal_hold got %h exp %h", obs, exp); end
    // other bits ignored: behaves as pass
    stall = 6'b100111;
    tick();
    exp = mk(5'd13, 1'b0, 32'h5, 1'b0, 1'b0, 32'h6, 32'h7, 64'h0, 2'd0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL ignored_pass got %h exp %h", obs, exp); end
    // other bits ignored: behaves as bubble, cnt 3 kept as 3
    stall = 6'b101111;
    set_ex(5'd14, 1'b1, 32'h9, 1'b1, 1'b1, 32'h1, 32'h2, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3);
    tick();
    exp = mk(5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL ignored_bubble_cnt3 got %h exp %h", obs, exp); end
  endtask

  task automatic test_reset_mid_stall();
    logic [169:0] exp;
    stall = 6'b001000;
    set_ex(5'd5, 1'b1, 32'h55, 1'b0, 1'b0, 32'h0, 32'h0, 64'h1234_5678_9ABC_DEF0, 2'd2);
    tick();
    rst = 1'b1; stall = 6'b011000;
    tick();
    exp = '0;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL rst_mid_stall got %h exp %h", obs, exp); end
    // first edge after reset: hold keeps the cleared state
    rst = 1'b0;
    tick();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL post_rst_hold got %h exp %h", obs, exp); end
    stall = 6'b0;
    tick();
    exp = mk(5'd5, 1'b1, 32'h55, 1'b0, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL post_rst_pass got %h exp %h", obs, exp); end
  endtask

`ifdef EX_MEM_FLUSH_EN
  task automatic test_flush();
    logic [169:0] exp;
    stall = 6'b0;
    set_ex(5'd17, 1'b1, 32'h7777, 1'b1, 1'b0, 32'h8, 32'h9, 64'h0, 2'd0);
    tick();
    flush = 1'b1; stall = 6'b011000;
    tick();
    exp = '0;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL flush_over_hold got %h exp %h", obs, exp); end
    flush = 1'b0; stall = 6'b001000;
    set_ex(5'd2, 1'b1, 32'h1, 1'b0, 1'b0, 32'h0, 32'h0, 64'h42, 2'd1);
    tick();
    flush = 1'b1;
    tick();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL flush_over_bubble got %h exp %h", obs, exp); end
    rst = 1'b1; flush = 1'b1; stall = 6'b0;
    tick();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL rst_and_flush got %h exp %h", obs, exp); end
    rst = 1'b0; flush = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_pass();
    test_hilo();
    test_bubble();
    test_hold();
    test_stall_decode();
    test_reset_mid_stall();
`ifdef EX_MEM_FLUSH_EN
    test_flush();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem.md
EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- stall_i  in  6  per-stage stall vector; bit 3 = EX stalled, bit 4 = MEM stalled
- ex_waddr_i  in  5  EX destination register address
- ex_reg_we_i  in  1  EX register write enable
- ex_alu_res_i  in  32  EX result
- ex_hi_we_i / ex_lo_we_i  in  1 each  EX Hi/Lo write enables
- ex_hi_i / ex_lo_i  in  32 each  EX Hi/Lo write data
- hilo_temp_i  in  64  EX partial multiply-accumulate product
- cnt_i  in  2  EX multi-cycle step count
- mem_waddr_o  out  5  registered destination address
- mem_reg_we_o  out  1  registered write enable
- mem_alu_res_o  out  32  registered result
- mem_hi_we_o / mem_lo_we_o  out  1 each  registered Hi/Lo write enables
- mem_hi_o / mem_lo_o  out  32 each  registered Hi/Lo data
- hilo_temp_o  out  64  partial product fed back to EX
- cnt_o  out  2  step count fed back to EX
- flush_i  in  1  pipeline flush; exists only with EX_MEM_FLUSH_EN

Function
REQ-002 All outputs SHALL be registers updated only on the rising edge of clk.
REQ-003 Pass: when stall_i[3]=0, every mem_* output SHALL take its ex_* input on the next edge (latency 1 cycle), and hilo_temp_o, cnt_o SHALL clear to 0.
REQ-004 Bubble: when stall_i[3]=1 and stall_i[4]=0, all mem_* outputs SHALL clear to 0 (write enables low), and hilo_temp_o, cnt_o SHALL load hilo_temp_i, cnt_i.
REQ-005 Hold: when stall_i[3]=1 and stall_i[4]=1, all outputs, including hilo_temp_o and cnt_o, SHALL keep their values.
REQ-006 stall_i[3]=0 with stall_i[4]=1 is illegal upstream; the block SHALL treat it as Hold.
REQ-007 stall_i bits other than 3 and 4 SHALL be ignored.
REQ-008 Priority per edge SHALL be rst > flush_i (if compiled) > stall decode.
REQ-009 A Bubble followed by Pass SHALL deliver the stalled instruction exactly once, and no duplicate write enable SHALL reach MEM.
REQ-010 cnt_o SHALL be stored unmodified: no increment and no wrap; a value of 3 SHALL be passed back as 3.

Reset
REQ-011 When rst=1 at an edge, all outputs SHALL become 0: addresses, data, write enables, hilo_temp_o and cnt_o.
REQ-012 rst asserted mid-stall or mid-multi-cycle SHALL discard the held instruction and the held hilo_temp/cnt, and the first edge after rst deasserts SHALL follow REQ-003 to REQ-006.

Configuration
REQ-013 Macro EX_MEM_FLUSH_EN defined: the flush_i port SHALL exist, and flush_i=1 SHALL clear all outputs exactly as reset does, overriding any stall.
REQ-014 Macro EX_MEM_FLUSH_EN undefined: the flush_i port SHALL be absent and behaviour SHALL be REQ-002 to REQ-012 only.

Verification
REQ-015 rst=1 with ex_alu_res_i=32'hDEADBEEF and ex_reg_we_i=1 -> one edge later all outputs are 0.
REQ-016 stall_i=0, ex_waddr_i=5'd7, ex_alu_res_i=32'h1234_5678, ex_reg_we_i=1 -> next edge mem_waddr_o=7, mem_alu_res_o=32'h12345678, mem_reg_we_o=1, cnt_o=0.
REQ-017 stall_i=6'b001000, hilo_temp_i=64'h0000_0001_FFFF_FFFF, cnt_i=1, ex_reg_we_i=1 -> mem_reg_we_o=0, hilo_temp_o=64'h00000001FFFFFFFF, cnt_o=1; then stall_i=0 -> hilo_temp_o=0 and the EX values are latched.
REQ-018 Outputs loaded, then stall_i=6'b011000 for 3 cycles while the inputs change -> outputs are unchanged for all 3 cycles.
REQ-019 ex_hi_we_i=1, ex_hi_i=32'hA5A5A5A5, stall_i=0 -> mem_hi_we_o=1, mem_hi_o=32'hA5A5A5A5, mem_lo_we_o=0.
REQ-020 With EX_MEM_FLUSH_EN defined: flush_i=1 and stall_i=6'b011000 with outputs loaded -> next edge all outputs are 0; rst=1 with flush_i=1 -> all outputs are 0.
